// File: rtl/hex_counter_defs.sv
// rtl/hex_counter_defs.sv - shared encodings and constants for the hex counter controller
//
// Purpose : run-state encoding, saturate/wrap mode encoding, synchroniser
//           depth and a width helper shared by hex_counter_ctrl and
//           button_sync_edge.
// Ports   : none (package).

package hex_counter_defs;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_RUN  = 1'b1
   } run_state_t;

   localparam int MODE_WRAP   = 0;
   localparam int MODE_SAT    = 1;

   localparam int SYNC_STAGES = 2;

   // Bits needed to hold 0..p-1; never less than one bit.
   function automatic int count_width(input int p);
      return (p > 1) ? $clog2(p) : 1;
   endfunction

endpackage

// File: rtl/hex_counter_ctrl_button_sync_edge.sv
// rtl/hex_counter_ctrl_button_sync_edge.sv - push-button synchroniser with press-edge detector
//
// Purpose : brings an asynchronous active-low push button into the Clock
//           domain through SYNC_STAGES flops, keeps a previous-level register
//           and emits a registered one-cycle press pulse on a 1->0 edge of
//           the synchronised level. All flops preset to the unpressed state.
// Ports   :
//   Clock     in   system clock
//   Reset     in   asynchronous active-high reset
//   button_n  in   asynchronous active-low button
//   level     out  synchronised button level (0 = pressed), registered
//   press     out  one-cycle pulse per press, registered

module button_sync_edge
   import hex_counter_defs::*;
(
   input  logic Clock,
   input  logic Reset,
   input  logic button_n,
   output logic level,
   output logic press
);

   localparam int FILL_W = $clog2(SYNC_STAGES + 1);
   localparam logic [FILL_W-1:0] FILL_DONE = FILL_W'(SYNC_STAGES);

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   prev_q;
   logic                   press_q;
   logic                   armed_q;
   logic [FILL_W-1:0]      fill_q;

   // The preset synchroniser contents are not a real sample. Edge detection
   // is armed only once a genuine sample has reached the last stage and shows
   // the button released, so a button held through reset never counts as a
   // press until it has been let go and pushed again.
   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) begin
         sync_q  <= '1;
         prev_q  <= 1'b1;
         press_q <= 1'b0;
         armed_q <= 1'b0;
         fill_q  <= '0;
      end else begin
         sync_q  <= {sync_q[SYNC_STAGES-2:0], button_n};
         prev_q  <= sync_q[SYNC_STAGES-1];
         press_q <= armed_q & prev_q & ~sync_q[SYNC_STAGES-1];
         if (fill_q != FILL_DONE) begin
            fill_q <= fill_q + 1'b1;
         end else if (sync_q[SYNC_STAGES-1]) begin
            armed_q <= 1'b1;
         end
      end
   end

   // Level is taken from the previous-value register so that Clear and the
   // press pulse both act on the third edge after the button is sampled.
   assign level = prev_q;
   assign press = press_q;

endmodule

// File: rtl/hex_counter_ctrl.sv
// rtl/hex_counter_ctrl.sv - run/stop up/down counter with prescaler, load and terminal pulse
//
// Purpose : counter feeding the hex-digit decoder chain. Push buttons start,
//           stop and clear; a prescaler sets the count rate; the counter
//           runs up or down, loads a clamped value and either wraps or
//           saturates (and stops) at its terminal value.
// Ports   :
//   Clock       in   system clock
//   Reset       in   asynchronous active-high reset
//   Start_n     in   async active-low button, press = start
//   Stop_n      in   async active-low button, press = stop
//   Clear_n     in   async active-low button, held low = clear
//   Up          in   direction, 1 = up, 0 = down
//   Load        in   single-cycle strobe, load Load_value
//   Load_value  in   load value, clamped to MAX_VALUE
//   Q           out  count value, 0..MAX_VALUE
//   Running     out  run state
//   Tc          out  one-cycle terminal-count pulse

module hex_counter_ctrl
   import hex_counter_defs::*;
#(
   parameter int WIDTH     = 20,
   parameter int MAX_VALUE = 2**WIDTH - 1,
   parameter int PRESCALE  = 1,
   parameter int SAT_MODE  = MODE_WRAP
)
(
   input  logic             Clock,
   input  logic             Reset,
   input  logic             Start_n,
   input  logic             Stop_n,
   input  logic             Clear_n,
   input  logic             Up,
   input  logic             Load,
   input  logic [WIDTH-1:0] Load_value,
   output logic [WIDTH-1:0] Q,
   output logic             Running,
   output logic             Tc
);

   localparam logic [WIDTH-1:0] MAX_Q   = WIDTH'(MAX_VALUE);
   localparam int               PS_W    = count_width(PRESCALE);
   localparam logic [PS_W-1:0]  PS_LAST = PS_W'(PRESCALE - 1);
   localparam bit               SAT     = (SAT_MODE == MODE_SAT);

   run_state_t       state;
   logic [WIDTH-1:0] q_r;
   logic [PS_W-1:0]  presc_r;
   logic             tc_r;

   logic             start_press;
   logic             stop_press;
   logic             clear_level;
   logic             start_level;
   logic             stop_level;
   logic             unused_levels;

   logic [WIDTH-1:0] q_step;
   logic             tc_step;
   logic             sat_stop;
   logic [WIDTH-1:0] load_clamped;
   logic             do_tick;

   button_sync_edge u_start (
      .Clock    (Clock),
      .Reset    (Reset),
      .button_n (Start_n),
      .level    (start_level),
      .press    (start_press)
   );

   button_sync_edge u_stop (
      .Clock    (Clock),
      .Reset    (Reset),
      .button_n (Stop_n),
      .level    (stop_level),
      .press    (stop_press)
   );

   // Clear is level-sensitive; its press pulse has no use here.
   logic clear_press;

   button_sync_edge u_clear (
      .Clock    (Clock),
      .Reset    (Reset),
      .button_n (Clear_n),
      .level    (clear_level),
      .press    (clear_press)
   );

   // Start/Stop act on edges only; their levels are not needed.
   assign unused_levels = start_level & stop_level & clear_press;

   assign load_clamped = (Load_value > MAX_Q) ? MAX_Q : Load_value;

   // A tick is only taken when neither Clear nor Load overrides it.
   assign do_tick = (state == ST_RUN) && (presc_r == PS_LAST) && clear_level && !Load;

   // Next count for a tick, including terminal handling in both directions.
   always_comb begin
      q_step   = q_r;
      tc_step  = 1'b0;
      sat_stop = 1'b0;
      if (Up) begin
         if (q_r == MAX_Q) begin
            tc_step = 1'b1;
            if (SAT) sat_stop = 1'b1;
            else     q_step   = '0;
         end else begin
            q_step = q_r + 1'b1;
         end
      end else begin
         if (q_r == '0) begin
            tc_step = 1'b1;
            if (SAT) sat_stop = 1'b1;
            else     q_step   = MAX_Q;
         end else begin
            q_step = q_r - 1'b1;
         end
      end
   end

   // Run FSM, prescaler, count register and terminal pulse share one process
   // so that a saturating tick and the auto-stop land on the same edge.
   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) begin
         state   <= ST_IDLE;
         q_r     <= '0;
         presc_r <= '0;
         tc_r    <= 1'b0;
      end else begin
         tc_r <= 1'b0;

         case (state)
            ST_IDLE: if (start_press && !stop_press) state <= ST_RUN;
            ST_RUN:  if (stop_press || (do_tick && sat_stop)) state <= ST_IDLE;
            default: state <= ST_IDLE;
         endcase

         if (!clear_level) begin
            q_r     <= '0;
            presc_r <= '0;
         end else if (Load) begin
            q_r     <= load_clamped;
            presc_r <= '0;
         end else if (state == ST_RUN) begin
            if (presc_r == PS_LAST) begin
               presc_r <= '0;
               q_r     <= q_step;
               tc_r    <= tc_step;
            end else begin
               presc_r <= presc_r + 1'b1;
            end
         end
      end
   end

   assign Q       = q_r;
   assign Running = (state == ST_RUN);
   assign Tc      = tc_r;

endmodule

// File: doc/hex_counter_ctrl.md
Name: hex_counter_ctrl

Overview:
Parametrised run/stop counter; next generation of the lab hex counter that drives the HEX display chain. Adds:
- synchronised, edge-detected push-button inputs
- a tick prescaler
- up/down direction and parallel load
- programmable terminal value with wrap or saturate mode
- terminal-count pulse
Q feeds the existing hex-digit decoder stage unchanged.

Parameters:
WIDTH, 20, counter width in bits.
MAX_VALUE, 2**WIDTH-1, terminal count for up-counting; legal range 1..2**WIDTH-1.
PRESCALE, 1, clock cycles per count step while running; 1 = every cycle; legal range 1..2**16.
SAT_MODE, 0, 0 = wrap at terminal, 1 = saturate at terminal and auto-stop.

Ports:
Clock  in  1  system clock; all state updates on rising edge.
Reset  in  1  asynchronous, active-high reset.
Start_n  in  1  active-low push button, asynchronous to Clock; press = start counting.
Stop_n  in  1  active-low push button, asynchronous; press = stop counting.
Clear_n  in  1  active-low push button, asynchronous; held low = clear.
Up  in  1  direction, synchronous to Clock: 1 = up, 0 = down.
Load  in  1  synchronous single-cycle strobe: load Load_value.
Load_value  in  WIDTH  value for Load; values above MAX_VALUE clamp to MAX_VALUE.
Q  out  WIDTH  count value, registered, range 0..MAX_VALUE.
Running  out  1  registered run state.
Tc  out  1  one-cycle pulse on the step that reaches or crosses terminal.

Behaviour:
- Reset asserted, any time including mid-count: Q=0, Running=0, Tc=0, prescaler=0, all synchroniser flops=1 (unpressed). No button edge is detected on the first cycles after reset release.
- Button path, per input: two-flop synchroniser, then a previous-value register.
  - Press event = synchronised level 0 while previous level is 1.
  - A button sampled low at edge k is acted on at edge k+3: Running changes, or Clear takes effect.
  - Holding a button does not re-trigger the press event; Clear_n is level-sensitive after synchronisation.
- Run FSM, states IDLE (Running=0) and RUN (Running=1):
  - IDLE→RUN on Start press.
  - RUN→IDLE on Stop press.
  - RUN→IDLE on saturation when SAT_MODE=1.
  - Start and Stop press in the same cycle: Stop wins.
  - Start press while in RUN, or Stop press while in IDLE: no effect.
- Prescaler: counts 0..PRESCALE-1 only while Running=1; holds its value in IDLE, so a partial interval resumes.
  - tick = Running and prescaler==PRESCALE-1; prescaler then returns to 0.
  - PRESCALE=1 gives tick on every running cycle.
- Update priority per cycle: Reset > Clear > Load > tick.
  - Clear (synchronised Clear_n low): Q=0 and prescaler=0; Running unchanged.
  - Load: Q=min(Load_value, MAX_VALUE) and prescaler=0; Running unchanged; Tc=0.
  - Tick, Up=1:
    - Q<MAX_VALUE: Q+1.
    - Q==MAX_VALUE, SAT_MODE=0: Q=0, Tc=1.
    - Q==MAX_VALUE, SAT_MODE=1: Q holds, Tc=1, Running=0 on the same edge.
  - Tick, Up=0:
    - Q>0: Q-1.
    - Q==0, SAT_MODE=0: Q=MAX_VALUE, Tc=1.
    - Q==0, SAT_MODE=1: Q holds, Tc=1, Running=0.
  - Direction change takes effect on the next tick with no extra latency.
- Tc is 0 on every cycle without a terminal tick; its maximum width is 1 cycle.
- When not Running and with no Clear or Load, Q holds.
- All arithmetic is done at WIDTH bits; no out-of-range Q value is ever produced.

Decomposition:
- Shared package/include (hex_counter_defs): run-state encodings ST_IDLE/ST_RUN, SAT_MODE encodings MODE_WRAP/MODE_SAT, synchroniser depth constant SYNC_STAGES=2.
- Sub-module button_sync_edge:
  - input: async active-low button.
  - outputs: synchronised level and single-cycle press pulse.
  - reset preset to 1.
  - instantiated three times: Start_n, Stop_n, Clear_n.
- Top module holds the FSM, prescaler, counter datapath and Tc register.

Test Plan:
1. WIDTH=4, MAX_VALUE=9, PRESCALE=1, SAT_MODE=0, Up=1: Start pulse low for 1 cycle at edge k → Running=1 at edge k+3; Q steps 0..9, then 0 with Tc=1 on the 9→0 edge only.
2. Same config, Up=0 from Q=0 while running → Q=9, Tc=1, then 8,7,…; Start and Stop pressed in the same cycle → Running=0 three edges later, Q frozen.
3. PRESCALE=4: Start, then Stop after 6 running cycles → Q=1 with prescaler=2; Start again → next increment exactly 2 running cycles later (Q=2).
4. SAT_MODE=1, MAX_VALUE=9, Up=1: Load_value=12 → Q=9; Start → on first tick Tc=1, Running=0, Q stays 9; further Start presses yield one Tc pulse per tick and no change in Q.
5. Priority while running: Clear_n held low with a simultaneous Load=1 (Load_value=5) → Q=0 while Clear is active; after Clear release, Load → Q=5 and counting continues from 5.
6. Reset asserted asynchronously mid-count (Q=7, Running=1, Start_n held low) → Q=0, Running=0, Tc=0 immediately; after release with Start_n still low, Running stays 0 until Start_n is released and pressed again.
